// File: rtl/cd_out_arb.sv
// Round-robin arbiter sharing one router output port among NREQ input buffers,
// with an independent fairness pointer per VC. Optional grant statistics: CD_ARB_STATS_EN.
module cd_out_arb #(
   parameter int NREQ = 4,
   parameter int DW   = 64,
   parameter int CW   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              polarity,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic [1:0]        out_ready,
   output logic [NREQ-1:0]   gnt,
   output logic              out_valid,
   output logic              out_vc,
   output logic [DW-1:0]     out_data,
   output logic [NREQ*CW-1:0] grant_cnt
);

   localparam int PW = $clog2(NREQ);

   logic [1:0][PW-1:0] rr_reg;
   logic [PW-1:0]      rr_cur;
   logic [PW-1:0]      rr_next;
   logic [NREQ-1:0]    elig;
   logic [DW-1:0]      flit [NREQ];
   logic               win_found;
   logic [PW-1:0]      win_idx;
   logic [PW:0]        scan_idx;
   logic               grant_en;
   logic               out_valid_reg;
   logic               out_vc_reg;
   logic [DW-1:0]      out_data_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign flit[gi] = req_data[gi*DW +: DW];
         assign elig[gi] = req[gi] & (req_data[gi*DW+DW-1] == polarity);
      end
   endgenerate

   assign rr_cur = rr_reg[polarity];

   // First eligible index at or after the active VC's pointer, modulo NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, rr_cur} + (PW+1)'(k);
         if (scan_idx >= (PW+1)'(NREQ))
            scan_idx = scan_idx - (PW+1)'(NREQ);
         if (!win_found && elig[scan_idx[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[PW-1:0];
         end
      end
   end

   assign grant_en = ~reset & out_ready[polarity] & win_found;
   assign gnt      = grant_en ? (NREQ'(1) << win_idx) : '0;
   assign rr_next  = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_reg        <= '0;
         out_valid_reg <= 1'b0;
         out_vc_reg    <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         out_valid_reg <= grant_en;
         if (grant_en) begin
            rr_reg[polarity] <= rr_next;
            out_data_reg     <= flit[win_idx];
            out_vc_reg       <= polarity;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_vc    = out_vc_reg;
   assign out_data  = out_data_reg;

`ifdef CD_ARB_STATS_EN
   // Saturating per-requester grant counters.
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cnt
         logic [CW-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (reset)
               cnt_reg <= '0;
            else if (gnt[gi] && (cnt_reg != {CW{1'b1}}))
               cnt_reg <= cnt_reg + CW'(1);
         end
         assign grant_cnt[gi*CW +: CW] = cnt_reg;
      end
   endgenerate
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_cd_out_arb.sv
// Scoreboard bench for cd_out_arb (NREQ=4, DW=64, CW=4): directed steps with
// hand-computed grants; a monitor checks the registered flit path one cycle later.
module tb_cd_out_arb;

   localparam int NREQ = 4;
   localparam int DW   = 64;
   localparam int CW   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              polarity;
   logic [NREQ-1:0]   req;
   logic [NREQ*DW-1:0] req_data;
   logic [1:0]        out_ready;
   logic [NREQ-1:0]   gnt;
   logic              out_valid;
   logic              out_vc;
   logic [DW-1:0]     out_data;
   logic [NREQ*CW-1:0] grant_cnt;

   typedef struct {
      logic          v;
      logic          vc;
      logic [DW-1:0] d;
      string         name;
   } exp_t;

   exp_t        expq [$];
   int          checks = 0;
   int          errors = 0;
   int          serial = 0;
   logic          last_vc = 1'b0;
   logic [DW-1:0] last_d  = '0;
   int          cnt_m [NREQ];

   cd_out_arb #(.NREQ(NREQ), .DW(DW), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .polarity  (polarity),
      .req       (req),
      .req_data  (req_data),
      .out_ready (out_ready),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_vc    (out_vc),
      .out_data  (out_data),
      .grant_cnt (grant_cnt)
   );

   always #5 clk = ~clk;

   task automatic step(input logic rst, input logic pol, input logic [3:0] rq,
                       input logic [3:0] vcs, input logic [1:0] rdy,
                       input logic [3:0] exp_gnt, input string name);
      logic [DW-1:0] flits [NREQ];
      logic [CW-1:0] exp_cnt;
      exp_t e;
      @(posedge clk);
      #1;
      serial++;
      reset     = rst;
      polarity  = pol;
      req       = rq;
      out_ready = rdy;
      for (int i = 0; i < NREQ; i++) begin
         flits[i] = {vcs[i], 15'(i), 16'(serial), 32'hC0DE_0000 + 32'(i)};
         req_data[i*DW +: DW] = flits[i];
      end
      #3;
      checks++;
      if (gnt !== exp_gnt) begin
         errors++;
         $display("FAIL %s gnt: got %b required %b", name, gnt, exp_gnt);
      end
      for (int i = 0; i < NREQ; i++) begin
`ifdef CD_ARB_STATS_EN
         exp_cnt = CW'(cnt_m[i]);
`else
         exp_cnt = '0;
`endif
         checks++;
         if (grant_cnt[i*CW +: CW] !== exp_cnt) begin
            errors++;
            $display("FAIL %s grant_cnt[%0d]: got %h required %h",
                     name, i, grant_cnt[i*CW +: CW], exp_cnt);
         end
      end
      e.name = name;
      if (rst) begin
         e.v = 1'b0; e.vc = 1'b0; e.d = '0;
         last_vc = 1'b0; last_d = '0;
         for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
      end else if (exp_gnt != 4'b0000) begin
         e.v = 1'b1; e.vc = pol; e.d = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) begin
               e.d = flits[i];
               if (cnt_m[i] < 15) cnt_m[i]++;
            end
         end
         last_vc = e.vc; last_d = e.d;
      end else begin
         e.v = 1'b0; e.vc = last_vc; e.d = last_d;
      end
      expq.push_back(e);
      $display("step %0d %s: rst=%b pol=%b req=%b vcs=%b rdy=%b gnt=%b (exp %b)",
               serial, name, rst, pol, rq, vcs, rdy, gnt, exp_gnt);
   endtask

   // Monitor: compares the registered outputs one cycle after each step.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (expq.size() != 0) begin
            e = expq.pop_front();
            checks++;
            if (out_valid !== e.v || out_vc !== e.vc || out_data !== e.d) begin
               errors++;
               $display("FAIL %s out: got v=%b vc=%b d=%h required v=%b vc=%b d=%h",
                        e.name, out_valid, out_vc, out_data, e.v, e.vc, e.d);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; polarity = 1'b0; req = '0; req_data = '0; out_ready = 2'b11;
      for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;

      step(1, 0, 4'b0000, 4'b0000, 2'b11, 4'b0000, "reset");
      step(1, 0, 4'b1111, 4'b0000, 2'b11, 4'b0000, "reset_req");

      // all four VC0 requesters, rotating grants with wrap
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0001, "rr_a");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0010, "rr_b");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0100, "rr_c");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b1000, "rr_d");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0001, "rr_wrap");

      // VC1 requests only win in polarity-1 cycles
      step(0, 0, 4'b1010, 4'b1111, 2'b11, 4'b0000, "vc1_p0a");
      step(0, 1, 4'b1010, 4'b1111, 2'b11, 4'b0010, "vc1_p1a");
      step(0, 0, 4'b1010, 4'b1111, 2'b11, 4'b0000, "vc1_p0b");
      step(0, 1, 4'b1010, 4'b1111, 2'b11, 4'b1000, "vc1_p1b");
      step(0, 0, 4'b1010, 4'b1111, 2'b11, 4'b0000, "vc1_p0c");
      step(0, 1, 4'b1010, 4'b1111, 2'b11, 4'b0010, "vc1_p1c");
      step(0, 1, 4'b1010, 4'b1111, 2'b01, 4'b0000, "vc1_notready");
      step(0, 1, 4'b1010, 4'b1111, 2'b11, 4'b1000, "vc1_resume");

      // VC0 output buffer full: no grant, pointer held at 1
      step(0, 0, 4'b1111, 4'b0000, 2'b10, 4'b0000, "stall_a");
      step(0, 0, 4'b1111, 4'b0000, 2'b10, 4'b0000, "stall_b");
      step(0, 0, 4'b1111, 4'b0000, 2'b10, 4'b0000, "stall_c");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0010, "stall_resume");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0100, "stall_next");

      // interleaved VCs from a fresh reset
      step(1, 0, 4'b0000, 4'b0000, 2'b11, 4'b0000, "reset2");
      step(0, 0, 4'b1001, 4'b1000, 2'b11, 4'b0001, "ilv_p0a");
      step(0, 1, 4'b1001, 4'b1000, 2'b11, 4'b1000, "ilv_p1a");
      step(0, 0, 4'b1001, 4'b1000, 2'b11, 4'b0001, "ilv_p0b");
      step(0, 1, 4'b1001, 4'b1000, 2'b11, 4'b1000, "ilv_p1b");

      // reset in the middle of a stream (rr[0] is 1 here)
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0010, "mid_a");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0100, "mid_b");
      step(1, 0, 4'b1111, 4'b0000, 2'b11, 4'b0000, "mid_reset");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0001, "post_reset_a");
      step(0, 0, 4'b1111, 4'b0000, 2'b11, 4'b0010, "post_reset_b");

      // 20 grants to req1 saturate its 4-bit counter
      for (int n = 0; n < 20; n++)
         step(0, 0, 4'b0010, 4'b0000, 2'b11, 4'b0010, "sat");
      step(0, 0, 4'b0000, 4'b0000, 2'b11, 4'b0000, "idle_a");
      step(0, 0, 4'b0000, 4'b0000, 2'b11, 4'b0000, "idle_b");

      for (int n = 0; n < 10 && expq.size() != 0; n++) @(posedge clk);
      #3;
      if (expq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending required 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
